// File: rtl/cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cmd_pkg
// Description : Shared command-interface types and defaults for the SDRAM
//               controller, its testers and the block-RAM stand-in.
// Revision    : 1.0 - initial release
// ============================================================================
package cmd_pkg;

    localparam int CMD_ADDR_WIDTH = 25;
    localparam int CMD_DATA_WIDTH = 16;

    typedef struct packed {
        logic [CMD_ADDR_WIDTH-1:0] addr;
        logic                      write;
        logic [CMD_DATA_WIDTH-1:0] wdata;
    } cmd_t;

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_READY   = 2'd1,
        ST_REFRESH = 2'd2
    } cmd_state_e;

endpackage
`default_nettype wire

// File: rtl/cmd_mem_ram.sv
`default_nettype none
// ============================================================================
// Module      : cmd_mem_ram
// Description : Simple dual-port synchronous RAM, one write port and one
//               registered read port, inferred as block RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module cmd_mem_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rst_,
    input  logic                  i_wr_en,
    input  logic [DEPTH_LOG2-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [DEPTH_LOG2-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [2**DEPTH_LOG2];
    logic [DATA_WIDTH-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Output register only updates on a read, so it holds the last read word.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/cmd_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : cmd_mem_responder
// Description : Block-RAM stand-in for the SDRAM controller command port with
//               init stall, periodic refresh stalls and fixed read latency.
// Revision    : 1.0 - initial release
// ============================================================================
module cmd_mem_responder
    import cmd_pkg::*;
#(
    parameter int ADDR_WIDTH       = CMD_ADDR_WIDTH,
    parameter int DATA_WIDTH       = CMD_DATA_WIDTH,
    parameter int DEPTH_LOG2       = 10,
    parameter int READ_LATENCY     = 4,
    parameter int INIT_CYCLES      = 200,
    parameter int REFRESH_INTERVAL = 780,
    parameter int REFRESH_CYCLES   = 8
) (
    input  logic                  clk,
    input  logic                  rst_,
    output logic                  cmdReady,
    input  logic                  cmdTrigger,
    input  logic [ADDR_WIDTH-1:0] cmdAddr,
    input  logic                  cmdWrite,
    input  logic [DATA_WIDTH-1:0] cmdWriteData,
    output logic [DATA_WIDTH-1:0] cmdReadData,
    output logic                  cmdReadDataValid,
    output logic                  cmdAddrError
);

    localparam int c_CNT_MAX_A = (INIT_CYCLES > REFRESH_INTERVAL) ? INIT_CYCLES : REFRESH_INTERVAL;
    localparam int c_CNT_MAX   = (c_CNT_MAX_A > REFRESH_CYCLES) ? c_CNT_MAX_A : REFRESH_CYCLES;
    localparam int c_CNT_W     = $clog2(c_CNT_MAX + 1);
    localparam int c_STAGES    = READ_LATENCY - 1;

    localparam logic               c_REFRESH_EN = (REFRESH_INTERVAL != 0);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE    = 1;
    localparam logic [c_CNT_W-1:0] c_INIT_LAST  = c_CNT_W'(INIT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_REF_LAST   = c_REFRESH_EN ? c_CNT_W'(REFRESH_INTERVAL - 1) : '0;
    localparam logic [c_CNT_W-1:0] c_STALL_LAST = c_CNT_W'(REFRESH_CYCLES - 1);

    cmd_state_e            r_state;
    logic [c_CNT_W-1:0]    r_cnt;
    logic                  r_ready;
    logic                  r_rd_pend;
    logic                  r_addr_err;
    logic                  w_accept;
    logic                  w_wr;
    logic                  w_rd;
    logic                  w_addr_high;
    logic [DATA_WIDTH-1:0] w_ram_rd_data;

    assign w_accept    = cmdTrigger & r_ready;
    assign w_wr        = w_accept & cmdWrite;
    assign w_rd        = w_accept & ~cmdWrite;
    assign w_addr_high = (cmdAddr >> DEPTH_LOG2) != '0;

    // One counter serves the init stall, the refresh interval and the stall
    // length; it restarts at every state change.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
            r_ready <= 1'b0;
        end else begin
            unique case (r_state)
                ST_INIT: begin
                    if (r_cnt == c_INIT_LAST) begin
                        r_state <= ST_READY;
                        r_cnt   <= '0;
                        r_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                ST_READY: begin
                    if (c_REFRESH_EN && (r_cnt == c_REF_LAST)) begin
                        r_state <= ST_REFRESH;
                        r_cnt   <= '0;
                        r_ready <= 1'b0;
                    end else if (c_REFRESH_EN) begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                ST_REFRESH: begin
                    if (r_cnt == c_STALL_LAST) begin
                        r_state <= ST_READY;
                        r_cnt   <= '0;
                        r_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                default: begin
                    r_state <= ST_INIT;
                    r_cnt   <= '0;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_rd_pend  <= 1'b0;
            r_addr_err <= 1'b0;
        end else begin
            r_rd_pend  <= w_rd;
            r_addr_err <= r_addr_err | (w_accept & w_addr_high);
        end
    end

    cmd_mem_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk       (clk),
        .rst_      (rst_),
        .i_wr_en   (w_wr),
        .i_wr_addr (cmdAddr[DEPTH_LOG2-1:0]),
        .i_wr_data (cmdWriteData),
        .i_rd_en   (w_rd),
        .i_rd_addr (cmdAddr[DEPTH_LOG2-1:0]),
        .o_rd_data (w_ram_rd_data)
    );

    generate
        if (READ_LATENCY == 1) begin : g_lat_direct
            assign cmdReadDataValid = r_rd_pend;
            assign cmdReadData      = w_ram_rd_data;
        end else begin : g_lat_pipe
            logic [c_STAGES-1:0]   r_pipe_vld;
            logic [DATA_WIDTH-1:0] r_pipe_dat [c_STAGES];

            // Data stages load only behind a valid so the output holds its last word.
            always_ff @(posedge clk or negedge rst_) begin
                if (!rst_) begin
                    r_pipe_vld <= '0;
                    for (int i = 0; i < c_STAGES; i++) begin
                        r_pipe_dat[i] <= '0;
                    end
                end else begin
                    r_pipe_vld[0] <= r_rd_pend;
                    if (r_rd_pend) begin
                        r_pipe_dat[0] <= w_ram_rd_data;
                    end
                    for (int i = 1; i < c_STAGES; i++) begin
                        r_pipe_vld[i] <= r_pipe_vld[i-1];
                        if (r_pipe_vld[i-1]) begin
                            r_pipe_dat[i] <= r_pipe_dat[i-1];
                        end
                    end
                end
            end

            assign cmdReadDataValid = r_pipe_vld[c_STAGES-1];
            assign cmdReadData      = r_pipe_dat[c_STAGES-1];
        end
    endgenerate

    assign cmdReady     = r_ready;
    assign cmdAddrError = r_addr_err;

endmodule
`default_nettype wire

// File: tb/tb_cmd_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_cmd_mem_responder
// Description : Self-checking bench; two responders (default timing and a
//               short refresh period) checked every cycle against a model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cmd_mem_responder;

    localparam int INIT = 200;
    localparam int LAT  = 4;

    logic        clk  = 1'b0;
    logic        rst_ = 1'b1;
    logic [1:0]  trig = 2'b00;
    logic [24:0] cmd_addr  = '0;
    logic        cmd_wr    = 1'b0;
    logic [15:0] cmd_wdata = '0;
    logic [1:0]  rdy;
    logic [1:0]  vld;
    logic [1:0]  err;
    logic [15:0] rdata [2];

    int  n_checks = 0;
    int  n_fail   = 0;
    bit  started  = 1'b0;

    always #5 clk = ~clk;

    cmd_mem_responder dut0 (
        .clk              (clk),
        .rst_             (rst_),
        .cmdReady         (rdy[0]),
        .cmdTrigger       (trig[0]),
        .cmdAddr          (cmd_addr),
        .cmdWrite         (cmd_wr),
        .cmdWriteData     (cmd_wdata),
        .cmdReadData      (rdata[0]),
        .cmdReadDataValid (vld[0]),
        .cmdAddrError     (err[0])
    );

    cmd_mem_responder #(
        .REFRESH_INTERVAL (16),
        .REFRESH_CYCLES   (8)
    ) dut1 (
        .clk              (clk),
        .rst_             (rst_),
        .cmdReady         (rdy[1]),
        .cmdTrigger       (trig[1]),
        .cmdAddr          (cmd_addr),
        .cmdWrite         (cmd_wr),
        .cmdWriteData     (cmd_wdata),
        .cmdReadData      (rdata[1]),
        .cmdReadDataValid (vld[1]),
        .cmdAddrError     (err[1])
    );

    task automatic check(input string name, input int d, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s dut%0d @%0t: got %0h, expected %0h", name, d, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic bit f_ready(input int kk, input int ri, input int rc);
        if (kk < INIT - 1) return 1'b0;
        if (ri == 0) return 1'b1;
        return ((kk - (INIT - 1)) % (ri + rc)) < ri;
    endfunction

    function automatic int f_ri(input int d);
        return (d == 0) ? 780 : 16;
    endfunction

    int          k [2];
    bit          m_ready [2];
    bit          m_valid [2];
    bit          m_err   [2];
    bit          m_known [2];
    logic [15:0] m_data  [2];
    logic [15:0] m_mem [int];
    bit          h_v     [2][16];
    bit          h_known [2][16];
    logic [15:0] h_d     [2][16];

    always @(posedge clk or negedge rst_) begin : p_model
        int slot;
        int key;
        if (!rst_) begin
            for (int d = 0; d < 2; d++) begin
                k[d] = -1;
                m_ready[d] = 1'b0;
                m_valid[d] = 1'b0;
                m_err[d]   = 1'b0;
                m_known[d] = 1'b1;
                m_data[d]  = '0;
                for (int s = 0; s < 16; s++) h_v[d][s] = 1'b0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                k[d]++;
                slot = k[d] % 16;
                h_v[d][slot] = 1'b0;
                if (trig[d] && m_ready[d]) begin
                    key = d * 1024 + int'(cmd_addr[9:0]);
                    if (cmd_addr >= 25'd1024) m_err[d] = 1'b1;
                    if (cmd_wr) begin
                        m_mem[key] = cmd_wdata;
                    end else begin
                        h_v[d][slot]     = 1'b1;
                        h_known[d][slot] = m_mem.exists(key);
                        h_d[d][slot]     = m_mem.exists(key) ? m_mem[key] : 16'h0;
                    end
                end
                m_ready[d] = f_ready(k[d], f_ri(d), 8);
                m_valid[d] = 1'b0;
                if (k[d] - LAT + 1 >= 0) begin
                    slot = (k[d] - LAT + 1) % 16;
                    if (h_v[d][slot]) begin
                        m_valid[d] = 1'b1;
                        m_data[d]  = h_d[d][slot];
                        m_known[d] = h_known[d][slot];
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            for (int d = 0; d < 2; d++) begin
                check("model_ready", d, rdy[d], m_ready[d]);
                check("model_valid", d, vld[d], m_valid[d]);
                check("model_err", d, err[d], m_err[d]);
                if (m_known[d]) check("model_rdata", d, rdata[d], m_data[d]);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_ready(input int d);
        int n = 0;
        while (!rdy[d] && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!rdy[d]) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_ready dut%0d: timed out after %0d cycles", d, n);
        end
    endtask

    task automatic issue(input int d, input bit w, input logic [24:0] a, input logic [15:0] wd);
        wait_ready(d);
        cmd_wr    = w;
        cmd_addr  = a;
        cmd_wdata = wd;
        trig[d]   = 1'b1;
        @(negedge clk);
        trig[d]   = 1'b0;
    endtask

    task automatic wait_valid(input int d, output int lat);
        lat = 1;
        while (!vld[d] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          lat;
        int          ns;
        int          first;
        int          last;
        logic [15:0] vals [16];
        int          lows;
        int          acc;
        int          strb;
        int          stall_strb;
        logic [15:0] exp_q [$];
        logic [15:0] e;

        #1 rst_ = 1'b0;
        started = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_ready", 0, rdy[0], 0);
        check("reset_err", 0, err[0], 0);

        // Init stall with a read of address 0 held on the bus
        cmd_addr = '0;
        cmd_wr   = 1'b0;
        trig[0]  = 1'b1;
        #2 rst_ = 1'b1;
        n = 0;
        while (!rdy[0] && n < 1000) begin
            n++;
            @(negedge clk);
        end
        check("init_stall_cycles", 0, n, 200);
        @(negedge clk);
        trig[0] = 1'b0;
        wait_valid(0, lat);
        check("init_read_latency", 0, lat, 4);

        // Write then read on the next edge
        issue(0, 1'b1, 25'h005, 16'h1234);
        issue(0, 1'b0, 25'h005, 16'h0000);
        wait_valid(0, lat);
        check("wr_rd_latency", 0, lat, 4);
        check("wr_rd_data", 0, rdata[0], 16'h1234);

        // Back-to-back reads of pre-written addresses
        for (int i = 0; i < 10; i++) issue(0, 1'b1, 25'(i), ~16'(i));
        wait_ready(0);
        ns = 0;
        first = -1;
        last = -1;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    cmd_addr = 25'(i);
                    cmd_wr   = 1'b0;
                    trig[0]  = 1'b1;
                    @(negedge clk);
                end
                trig[0] = 1'b0;
            end
            begin
                for (int c = 0; c < 30; c++) begin
                    @(negedge clk);
                    if (vld[0]) begin
                        if (ns < 16) vals[ns] = rdata[0];
                        if (ns == 0) first = c;
                        last = c;
                        ns++;
                    end
                end
            end
        join
        check("pipe_strobe_count", 0, ns, 10);
        check("pipe_strobe_span", 0, last - first, 9);
        for (int i = 0; i < 10; i++) check("pipe_value", 0, vals[i], 16'hFFFF - 16'(i));

        // Aliasing and sticky error
        check("err_before_alias", 0, err[0], 0);
        issue(0, 1'b1, 25'h400, 16'hBEEF);
        issue(0, 1'b0, 25'h000, 16'h0000);
        wait_valid(0, lat);
        check("alias_latency", 0, lat, 4);
        check("alias_data", 0, rdata[0], 16'hBEEF);
        check("alias_err", 0, err[0], 1);

        // Refresh stalls on the short-interval instance
        for (int i = 0; i < 16; i++) issue(1, 1'b1, 25'(i), 16'hA000 + 16'(i));
        lows = 0;
        acc = 0;
        strb = 0;
        stall_strb = 0;
        for (int i = 0; i < 106; i++) begin
            if (vld[1]) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hDEAD;
                check("rf_order", 1, rdata[1], e);
                strb++;
                if (!rdy[1]) stall_strb++;
            end
            if (i < 72 && !rdy[1]) lows++;
            if (i < 96) begin
                cmd_addr = 25'(i % 16);
                cmd_wr   = 1'b0;
                trig[1]  = 1'b1;
                if (rdy[1]) begin
                    exp_q.push_back(16'hA000 + 16'(i % 16));
                    acc++;
                end
            end else begin
                trig[1] = 1'b0;
            end
            @(negedge clk);
        end
        check("rf_low_cycles_per_72", 1, lows, 24);
        check("rf_accepts_vs_strobes", 1, strb, acc);
        check("rf_strobes_during_stall", 1, (stall_strb > 0), 1);
        check("err_still_set", 0, err[0], 1);

        // Reset with reads in flight
        wait_ready(0);
        for (int i = 1; i <= 3; i++) begin
            cmd_addr = 25'(i);
            cmd_wr   = 1'b0;
            trig[0]  = 1'b1;
            @(negedge clk);
        end
        trig[0] = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_ = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rst_valid", 0, vld[0], 0);
            check("rst_err", 0, err[0], 0);
            check("rst_ready", 0, rdy[0], 0);
        end
        #2 rst_ = 1'b1;
        n = 0;
        strb = 0;
        while (!rdy[0] && n < 1000) begin
            n++;
            if (vld[0]) strb++;
            @(negedge clk);
        end
        check("reinit_stall_cycles", 0, n, 200);
        repeat (10) begin
            @(negedge clk);
            if (vld[0]) strb++;
        end
        check("no_strobe_after_reset", 0, strb, 0);
        check("err_after_reset", 0, err[0], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
